// File: rtl/lsu_byte_initiator_if.sv
// rtl/lsu_byte_initiator_if.sv - byte-wide handshaked data-memory port
interface lsu_byte_initiator_if;
  logic        oMemReq;
  logic        oMemWe;
  logic [31:0] oMemAddr;
  logic [7:0]  oMemWData;
  logic        iMemAck;
  logic [7:0]  iMemRData;

  modport master (
    output oMemReq, oMemWe, oMemAddr, oMemWData,
    input  iMemAck, iMemRData
  );

  modport slave (
    input  oMemReq, oMemWe, oMemAddr, oMemWData,
    output iMemAck, iMemRData
  );
endinterface

// File: rtl/lsu_byte_initiator.sv
// rtl/lsu_byte_initiator.sv - load/store initiator serialising requests into byte transactions
module lsu_byte_initiator #(
  parameter int TIMEOUT = 255
) (
  input  logic                        iClk,
  input  logic                        iRstN,
  input  logic                        iReq,
  input  logic                        iMemRead,
  input  logic                        iMemWrite,
  input  logic [2:0]                  iFunct3,
  input  logic [31:0]                 iAddress,
  input  logic [31:0]                 iWriteData,
  output logic                        oBusy,
  output logic                        oDone,
  output logic                        oError,
  output logic [31:0]                 oReadData,
  lsu_byte_initiator_if.master        mem
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateE;

  stateE          state, stateNext;
  logic [31:0]    baseAddr;
  logic [31:0]    wData;
  logic [2:0]     funct3R;
  logic           isStore;
  logic [1:0]     idx;
  logic [1:0]     lastIdx;
  logic [CW-1:0]  waitCnt;
  logic [31:0]    rawData;
  logic [31:0]    readDataR;
  logic           errR;

  logic           reqLegal;
  logic           inAccess;
  logic           ackSeen;
  logic           lastByte;
  logic           timedOut;
  logic [31:0]    mergedData;
  logic [31:0]    extData;

  always_comb begin
    reqLegal = 1'b0;
    case (iFunct3)
      3'b000, 3'b001, 3'b010: reqLegal = 1'b1;
      3'b100, 3'b101:         reqLegal = !iMemWrite;
      default:                reqLegal = 1'b0;
    endcase
    reqLegal = reqLegal && (iMemRead ^ iMemWrite);
  end

  assign inAccess = (state == ACCESS);
  assign ackSeen  = inAccess && mem.iMemAck;
  assign lastByte = (idx == lastIdx);
  assign timedOut = (TIMEOUT != 0) && inAccess && !mem.iMemAck && (waitCnt == WAIT_LAST);

  // Lane idx is taken straight from the bus so the final byte can be extended on its ack edge.
  always_comb begin
    mergedData = rawData;
    mergedData[{idx, 3'b000} +: 8] = mem.iMemRData;
  end

  always_comb begin
    extData = mergedData;
    case (funct3R)
      3'b000:  extData = {{24{mergedData[7]}}, mergedData[7:0]};
      3'b001:  extData = {{16{mergedData[15]}}, mergedData[15:0]};
      3'b100:  extData = {24'h0, mergedData[7:0]};
      3'b101:  extData = {16'h0, mergedData[15:0]};
      default: extData = mergedData;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (iReq) stateNext = reqLegal ? ACCESS : DONE;
      ACCESS:  if ((ackSeen && lastByte) || timedOut) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      baseAddr  <= '0;
      wData     <= '0;
      funct3R   <= '0;
      isStore   <= 1'b0;
      idx       <= '0;
      lastIdx   <= '0;
      waitCnt   <= '0;
      rawData   <= '0;
      readDataR <= '0;
      errR      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iReq) begin
            baseAddr  <= iAddress;
            wData     <= iWriteData;
            funct3R   <= iFunct3;
            isStore   <= iMemWrite;
            idx       <= '0;
            lastIdx   <= iFunct3[1] ? 2'd3 : (iFunct3[0] ? 2'd1 : 2'd0);
            waitCnt   <= '0;
            rawData   <= '0;
            readDataR <= '0;
            errR      <= !reqLegal;
          end
        end
        ACCESS: begin
          if (ackSeen) begin
            if (!isStore) rawData <= mergedData;
            idx     <= idx + 2'd1;
            waitCnt <= '0;
            if (lastByte) readDataR <= isStore ? 32'h0 : extData;
          end else if (timedOut) begin
            errR      <= 1'b1;
            readDataR <= '0;
          end else begin
            waitCnt <= waitCnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign oBusy         = (state != IDLE);
  assign oDone         = (state == DONE);
  assign oError        = oDone && errR;
  assign oReadData     = readDataR;
  assign mem.oMemReq   = inAccess;
  assign mem.oMemWe    = inAccess && isStore;
  assign mem.oMemAddr  = inAccess ? (baseAddr + {30'h0, idx}) : 32'h0;
  assign mem.oMemWData = (inAccess && isStore) ? wData[{idx, 3'b000} +: 8] : 8'h0;

endmodule

// File: tb/tb_lsu_byte_initiator.sv
// tb/tb_lsu_byte_initiator.sv - directed vector bench for lsu_byte_initiator
module tb_lsu_byte_initiator;
  logic        iClk = 1'b0;
  logic        iRstN;
  logic        iReq;
  logic        iMemRead;
  logic        iMemWrite;
  logic [2:0]  iFunct3;
  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic        oBusy;
  logic        oDone;
  logic        oError;
  logic [31:0] oReadData;

  lsu_byte_initiator_if memIf ();

  lsu_byte_initiator #(.TIMEOUT(4)) dut (
    .iClk       (iClk),
    .iRstN      (iRstN),
    .iReq       (iReq),
    .iMemRead   (iMemRead),
    .iMemWrite  (iMemWrite),
    .iFunct3    (iFunct3),
    .iAddress   (iAddress),
    .iWriteData (iWriteData),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oError     (oError),
    .oReadData  (oReadData),
    .mem        (memIf.master)
  );

  always #5 iClk = ~iClk;

  logic [7:0]  memArr [0:1023];
  int          waitCnt;
  int          waitCfg;
  bit          stuck;
  bit          memInit;
  logic [31:0] ackLog [$];

  assign memIf.iMemAck   = memIf.oMemReq && !stuck && (waitCnt >= waitCfg);
  assign memIf.iMemRData = memArr[memIf.oMemAddr[9:0]];

  always @(posedge iClk) begin
    if (memInit) begin
      for (int i = 0; i < 1024; i++) memArr[i] <= 8'h00;
      memArr[10'h100] <= 8'h80;
      memArr[10'h101] <= 8'h7F;
      memArr[10'h102] <= 8'h01;
      memArr[10'h103] <= 8'hFF;
      memArr[10'h3FF] <= 8'h34;
      memArr[10'h000] <= 8'h12;
      waitCnt <= 0;
    end else begin
      if (memIf.oMemReq && !memIf.iMemAck) waitCnt <= waitCnt + 1;
      else                                 waitCnt <= 0;
      if (memIf.oMemReq && memIf.iMemAck) begin
        ackLog.push_back(memIf.oMemAddr);
        if (memIf.oMemWe) memArr[memIf.oMemAddr[9:0]] <= memIf.oMemWData;
      end
    end
  end

  int nVec = 0;
  int nErr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic doReq(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int wcfg, input bit stk, input bit hold,
                       output logic [31:0] data, output bit err,
                       output int lat, output int reqc);
    bit          pend = 0;
    logic [31:0] pAddr = 0;
    logic [7:0]  pData = 0;
    logic        pWe = 0;
    waitCfg = wcfg;
    stuck   = stk;
    ackLog.delete();
    iMemRead = rd; iMemWrite = wr; iFunct3 = f3; iAddress = addr; iWriteData = wdata;
    iReq = 1'b1;
    lat = -1; reqc = 0; data = 32'hx; err = 1'bx;
    for (int c = 1; c <= 60; c++) begin
      @(negedge iClk);
      if (!hold) iReq = 1'b0;
      if (pend && memIf.oMemReq) begin
        check("addr stable", memIf.oMemAddr, pAddr);
        check("wdata stable", {24'h0, memIf.oMemWData}, {24'h0, pData});
        check("we stable", {31'h0, memIf.oMemWe}, {31'h0, pWe});
      end
      pend = memIf.oMemReq && !memIf.iMemAck;
      pAddr = memIf.oMemAddr; pData = memIf.oMemWData; pWe = memIf.oMemWe;
      if (memIf.oMemReq) reqc++;
      if (oDone) begin
        data = oReadData;
        err  = oError;
        lat  = c;
        break;
      end
    end
    iReq = 1'b0;
    stuck = 0;
    @(negedge iClk);
  endtask

  typedef struct {
    string       name;
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wcfg;
    bit          stk;
    bit          hold;
    logic [31:0] expData;
    bit          expErr;
    int          expLat;
    int          expReq;
  } vecT;

  vecT vecs [$];

  logic [31:0] rData;
  bit          rErr;
  int          rLat;
  int          rReq;

  initial begin
    vecs.push_back('{"LW 100",      1, 0, 3'b010, 32'h100,      32'h0,        0, 0, 0, 32'hFF017F80, 0, 5, 4});
    vecs.push_back('{"LB 100",      1, 0, 3'b000, 32'h100,      32'h0,        0, 0, 0, 32'hFFFFFF80, 0, 2, 1});
    vecs.push_back('{"LBU 100",     1, 0, 3'b100, 32'h100,      32'h0,        0, 0, 0, 32'h00000080, 0, 2, 1});
    vecs.push_back('{"LH 101",      1, 0, 3'b001, 32'h101,      32'h0,        0, 0, 0, 32'h0000017F, 0, 3, 2});
    vecs.push_back('{"LHU 102",     1, 0, 3'b101, 32'h102,      32'h0,        0, 0, 0, 32'h0000FF01, 0, 3, 2});
    vecs.push_back('{"LH 102",      1, 0, 3'b001, 32'h102,      32'h0,        0, 0, 0, 32'hFFFFFF01, 0, 3, 2});
    vecs.push_back('{"SW 1FF",      0, 1, 3'b010, 32'h1FF,      32'hDEADBEEF, 2, 0, 0, 32'h00000000, 0, 13, 12});
    vecs.push_back('{"LW 1FF",      1, 0, 3'b010, 32'h1FF,      32'h0,        0, 0, 0, 32'hDEADBEEF, 0, 5, 4});
    vecs.push_back('{"ill f3 011",  1, 0, 3'b011, 32'h100,      32'h0,        0, 0, 0, 32'h00000000, 1, 1, 0});
    vecs.push_back('{"ill SB 100",  0, 1, 3'b100, 32'h100,      32'h55,       0, 0, 0, 32'h00000000, 1, 1, 0});
    vecs.push_back('{"ill rd+wr",   1, 1, 3'b010, 32'h100,      32'h0,        0, 0, 0, 32'h00000000, 1, 1, 0});
    vecs.push_back('{"ill none",    0, 0, 3'b000, 32'h100,      32'h0,        0, 0, 0, 32'h00000000, 1, 1, 0});
    vecs.push_back('{"LW timeout",  1, 0, 3'b010, 32'h100,      32'h0,        0, 1, 0, 32'h00000000, 1, 5, 4});
    vecs.push_back('{"LB 103",      1, 0, 3'b000, 32'h103,      32'h0,        0, 0, 0, 32'hFFFFFFFF, 0, 2, 1});
    vecs.push_back('{"LHU wrap hold", 1, 0, 3'b101, 32'hFFFFFFFF, 32'h0,      0, 0, 1, 32'h00001234, 0, 3, 2});

    iRstN = 1'b0; iReq = 1'b0; iMemRead = 1'b0; iMemWrite = 1'b0;
    iFunct3 = 3'b0; iAddress = 32'h0; iWriteData = 32'h0;
    waitCfg = 0; stuck = 0; memInit = 1;
    repeat (2) @(negedge iClk);
    check("reset outputs", {oBusy, oDone, oError, oReadData, memIf.oMemReq, memIf.oMemWe,
                            memIf.oMemAddr, memIf.oMemWData}, '0);
    check("reset readData", oReadData, 32'h0);
    memInit = 0;
    iRstN = 1'b1;
    @(negedge iClk);

    foreach (vecs[i]) begin
      doReq(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
            vecs[i].wcfg, vecs[i].stk, vecs[i].hold, rData, rErr, rLat, rReq);
      check({vecs[i].name, " data"}, rData, vecs[i].expData);
      check({vecs[i].name, " err"}, {31'h0, rErr}, {31'h0, vecs[i].expErr});
      check({vecs[i].name, " latency"}, rLat, vecs[i].expLat);
      check({vecs[i].name, " req cycles"}, rReq, vecs[i].expReq);
    end

    check("SW byte 1FF", {24'h0, memArr[10'h1FF]}, 32'hEF);
    check("SW byte 200", {24'h0, memArr[10'h200]}, 32'hBE);
    check("SW byte 201", {24'h0, memArr[10'h201]}, 32'hAD);
    check("SW byte 202", {24'h0, memArr[10'h202]}, 32'hDE);

    doReq(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 0, rData, rErr, rLat, rReq);
    check("LW addr count", ackLog.size(), 4);
    for (int k = 0; k < 4 && k < ackLog.size(); k++)
      check("LW addr seq", ackLog[k], 32'h100 + k);

    doReq(1, 0, 3'b101, 32'hFFFFFFFF, 32'h0, 0, 0, 0, rData, rErr, rLat, rReq);
    check("wrap addr count", ackLog.size(), 2);
    if (ackLog.size() == 2) begin
      check("wrap addr 0", ackLog[0], 32'hFFFFFFFF);
      check("wrap addr 1", ackLog[1], 32'h00000000);
    end

    // Reset lands while the second byte of a waited store is outstanding.
    waitCfg = 2; stuck = 0;
    iMemRead = 0; iMemWrite = 1; iFunct3 = 3'b010; iAddress = 32'h300; iWriteData = 32'hCAFEF00D;
    iReq = 1'b1;
    @(negedge iClk);
    iReq = 1'b0;
    repeat (4) @(negedge iClk);
    check("pre-reset byte1 addr", memIf.oMemAddr, 32'h301);
    iRstN = 1'b0;
    @(negedge iClk);
    check("mid reset outputs", {oBusy, oDone, oError, oReadData, memIf.oMemReq, memIf.oMemWe,
                                memIf.oMemAddr, memIf.oMemWData}, '0);
    iRstN = 1'b1;
    rLat = 0;
    repeat (4) begin
      @(negedge iClk);
      if (oDone || memIf.oMemReq) rLat++;
    end
    check("no done after reset", rLat, 0);
    check("partial store kept", {24'h0, memArr[10'h300]}, 32'h0D);
    check("unwritten byte", {24'h0, memArr[10'h301]}, 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
